// File: rtl/apb_reduce_master.sv
// APB read-and-reduce master: N_OPS read beats from a base address, summed into one result word.
// Optional build macro APB_REDUCE_SAT_EN selects an unsigned-saturating accumulator.
module apb_reduce_master #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned N_OPS     = 2,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              compute_req_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic [ADDR_W-1:0] paddr_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned       CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_OPS - 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                flag_q, flag_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;

    logic                first_beat;
    logic [DATA_W-1:0]   acc_base;
    logic [DATA_W-1:0]   acc_next;
    logic                flag_next;

    assign first_beat = (cnt_q == '0);
    // First beat of a group loads rather than adds, so a stale sum never leaks across groups.
    assign acc_base   = first_beat ? '0 : acc_q;
    assign flag_next  = (first_beat ? 1'b0 : flag_q) | pslverr_i;

`ifdef APB_REDUCE_SAT_EN
    logic [DATA_W:0] sum_wide;
    assign sum_wide = {1'b0, acc_base} + {1'b0, prdata_i};
    assign acc_next = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
`else
    assign acc_next = acc_base + prdata_i;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (compute_req_i) begin
                    state_d = StSetup;
                    addr_d  = start_addr_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready_i) begin
                    addr_d = addr_q + STEP;
                    acc_d  = acc_next;
                    flag_d = flag_next;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        data_d  = acc_next;
                        err_d   = flag_next;
                        valid_d = 1'b1;
                        state_d = compute_req_i ? StSetup : StIdle;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StSetup;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign psel_o    = (state_q != StIdle);
    assign penable_o = (state_q == StAccess);
    assign paddr_o   = psel_o ? addr_q : '0;
    assign pwrite_o  = 1'b0;
    assign pwdata_o  = '0;
    assign busy_o    = psel_o;
    assign data_o    = data_q;
    assign err_o     = err_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_apb_reduce_master.sv
// Scoreboard bench for apb_reduce_master (N_OPS=2): slave model checks addresses, monitor checks results.
module tb_apb_reduce_master;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        err;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } res_t;

    logic        clk;
    logic        preset;
    logic        req;
    logic [7:0]  start_addr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [7:0]  paddr;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] data;
    logic        valid, err, busy;

    beat_t beat_q[$];
    res_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    wcnt  = 0;
    int    cyc   = 0;
    int    t0;

    apb_reduce_master #(
        .DATA_W   (32),
        .ADDR_W   (8),
        .N_OPS    (2),
        .ADDR_STEP(1)
    ) u_dut (
        .pclk_i       (clk),
        .preset_i     (preset),
        .compute_req_i(req),
        .start_addr_i (start_addr),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .paddr_o      (paddr),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr),
        .data_o       (data),
        .valid_o      (valid),
        .err_o        (err),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_beat(input logic [7:0] a, input logic [31:0] d, input logic e,
                             input int w);
        beat_t b;
        b.addr = a; b.data = d; b.err = e; b.waits = w;
        beat_q.push_back(b);
    endtask

    task automatic push_res(input logic [31:0] d, input logic e);
        res_t r;
        r.data = d; r.err = e;
        exp_q.push_back(r);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        tick();
        while (!valid && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (!valid) begin
            fails++;
            $display("FAIL %s: got no valid_o within 60 cycles, required a result", name);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 80) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 80) begin
            fails++;
            $display("FAIL %s: got %0d results pending busy=%b, required drained idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic pulse_req(input logic [7:0] a);
        start_addr = a;
        req        = 1'b1;
        t0         = cyc;
        tick();
        req        = 1'b0;
    endtask

    // APB slave model: serves queued beats, checks paddr in SETUP and every ACCESS cycle.
    initial begin
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge clk);
            pready = 1'b0; prdata = '0; pslverr = 1'b0;
            if (psel && !preset) begin
                if (beat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_access: got paddr=%h, required no transfer", paddr);
                end else begin
                    chk("paddr", {24'h0, paddr}, {24'h0, beat_q[0].addr});
                    if (penable) begin
                        if (wcnt < beat_q[0].waits) begin
                            wcnt++;
                        end else begin
                            pready  = 1'b1;
                            prdata  = beat_q[0].data;
                            pslverr = beat_q[0].err;
                            wcnt    = 0;
                            void'(beat_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Result monitor: every valid_o strobe must match the oldest expected result.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got data_o=%h, required no result", data);
                end else begin
                    r = exp_q.pop_front();
                    chk("result_data", data, r.data);
                    chk("result_err", {31'h0, err}, {31'h0, r.err});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        preset = 1'b1; req = 1'b0; start_addr = '0;
        repeat (3) tick();
        chk("rst_psel", {31'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, penable}, 32'h0);
        chk("rst_paddr", {24'h0, paddr}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        preset = 1'b0;
        tick();

        // Single zero-wait group, one-cycle request.
        push_beat(8'h10, 32'd5, 1'b0, 0);
        push_beat(8'h11, 32'd7, 1'b0, 0);
        push_res(32'd12, 1'b0);
        pulse_req(8'h10);
        wait_valid("t1_valid");
        chk("t1_latency", cyc - t0, 32'd5);
        wait_done("t1_done");
        chk("t1_data_hold", data, 32'd12);
        chk("t1_idle", {31'h0, busy}, 32'h0);

        // Back-to-back groups with wait states; start_addr_i ignored on continuation.
        push_beat(8'h20, 32'd1, 1'b0, 0);
        push_beat(8'h21, 32'd2, 1'b0, 2);
        push_beat(8'h22, 32'd3, 1'b0, 0);
        push_beat(8'h23, 32'd4, 1'b0, 0);
        push_res(32'd3, 1'b0);
        push_res(32'd7, 1'b0);
        start_addr = 8'h20;
        req = 1'b1;
        t0 = cyc;
        tick();
        start_addr = 8'h99;
        wait_valid("t2_valid1");
        chk("t2_latency1", cyc - t0, 32'd7);
        chk("t2_b2b_setup", {30'h0, psel, penable}, 32'h2);
        req = 1'b0;
        wait_valid("t2_valid2");
        chk("t2_latency2", cyc - t0, 32'd11);
        wait_done("t2_done");

        // Address wrap across groups.
        push_beat(8'hFE, 32'd1, 1'b0, 0);
        push_beat(8'hFF, 32'd2, 1'b0, 0);
        push_beat(8'h00, 32'd3, 1'b0, 0);
        push_beat(8'h01, 32'd4, 1'b0, 0);
        push_res(32'd3, 1'b0);
        push_res(32'd7, 1'b0);
        start_addr = 8'hFE;
        req = 1'b1;
        wait_valid("t3_valid1");
        req = 1'b0;
        wait_valid("t3_valid2");
        wait_done("t3_done");

        // Slave error on first beat is sticky for the group; next clean group clears it.
        push_beat(8'h30, 32'd10, 1'b1, 0);
        push_beat(8'h31, 32'd20, 1'b0, 0);
        push_res(32'd30, 1'b1);
        pulse_req(8'h30);
        wait_valid("t4_valid1");
        wait_done("t4_done1");
        chk("t4_err_hold", {31'h0, err}, 32'h1);
        push_beat(8'h32, 32'd1, 1'b0, 0);
        push_beat(8'h33, 32'd1, 1'b0, 0);
        push_res(32'd2, 1'b0);
        pulse_req(8'h32);
        wait_valid("t4_valid2");
        wait_done("t4_done2");

        // Overflow behaviour.
        push_beat(8'h60, 32'hFFFF_FFFF, 1'b0, 0);
        push_beat(8'h61, 32'h0000_0002, 1'b0, 0);
`ifdef APB_REDUCE_SAT_EN
        push_res(32'hFFFF_FFFF, 1'b0);
`else
        push_res(32'h0000_0001, 1'b0);
`endif
        pulse_req(8'h60);
        wait_valid("t5_valid");
        wait_done("t5_done");

        // Reset in the middle of an ACCESS wait: bus dropped, no result, clean restart.
        push_beat(8'h40, 32'd100, 1'b0, 6);
        pulse_req(8'h40);
        n = 0;
        while (!penable && n < 20) begin
            tick();
            n++;
        end
        chk("t6_in_access", {31'h0, penable}, 32'h1);
        preset = 1'b1;
        tick();
        chk("t6_psel", {31'h0, psel}, 32'h0);
        chk("t6_penable", {31'h0, penable}, 32'h0);
        chk("t6_paddr", {24'h0, paddr}, 32'h0);
        chk("t6_valid", {31'h0, valid}, 32'h0);
        chk("t6_data", data, 32'h0);
        preset = 1'b0;
        beat_q.delete();
        wcnt = 0;
        repeat (4) tick();
        push_beat(8'h50, 32'd9, 1'b0, 0);
        push_beat(8'h51, 32'd1, 1'b0, 0);
        push_res(32'd10, 1'b0);
        pulse_req(8'h50);
        wait_valid("t6_valid_restart");
        wait_done("t6_done");

        chk("end_beats_left", beat_q.size(), 32'd0);
        chk("end_results_left", exp_q.size(), 32'd0);
        chk("pwrite", {31'h0, pwrite}, 32'h0);
        chk("pwdata", pwdata, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_reduce_master.md
# apb_reduce_master

Parametrised APB read-and-reduce master, the successor of the current two-word APB summing computer. On request it issues N_OPS consecutive APB read transfers starting at a programmable base address, accumulates the read words and presents one result word with a single-cycle valid strobe. It sits between the compute-control logic and the APB peripheral bus, supports back-to-back groups, wait states and slave-error reporting.

## Interface
- DATA_W, 32, APB data width and result width
- ADDR_W, 8, APB address width
- N_OPS, 2, read beats per result (2..256)
- ADDR_STEP, 1, address increment per beat
- pclk_i  input  1  clock, all logic on rising edge
- preset_i  input  1  synchronous, active-high reset
- compute_req_i  input  1  start / continue request (level)
- start_addr_i  input  ADDR_W  base address, sampled when a group starts from IDLE
- psel_o  output  1  APB select
- penable_o  output  1  APB enable
- pwrite_o  output  1  always 0 (read-only master)
- pwdata_o  output  DATA_W  always 0
- paddr_o  output  ADDR_W  APB address
- prdata_i  input  DATA_W  APB read data
- pready_i  input  1  APB ready
- pslverr_i  input  1  APB slave error
- data_o  output  DATA_W  registered result of last completed group
- valid_o  output  1  one-cycle strobe, data_o/err_o new
- err_o  output  1  at least one beat of the group returned pslverr_i
- busy_o  output  1  state != IDLE

## Operation
- FSM states IDLE, SETUP, ACCESS. IDLE->SETUP when compute_req_i=1. SETUP->ACCESS unconditionally. ACCESS holds while pready_i=0. ACCESS with pready_i=1: if beats remain -> SETUP; if last beat and compute_req_i=1 -> SETUP (next group); if last beat and compute_req_i=0 -> IDLE.
- Outputs: IDLE psel=0 penable=0 paddr=0; SETUP psel=1 penable=0; ACCESS psel=1 penable=1. paddr_o stable across SETUP and all ACCESS wait cycles.
- Address pointer: loaded with start_addr_i on IDLE->SETUP; += ADDR_STEP after every completed beat, modulo 2^ADDR_W (wraps 0xFF->0x00 silently). A continued group starts at last address + ADDR_STEP; start_addr_i ignored.
- Beat counter 0..N_OPS-1; cleared at group start and after last beat.
- Accumulator DATA_W bits: first beat loads prdata_i, subsequent beats add prdata_i, sum modulo 2^DATA_W (default build).
- Error sticky flag: set by any completed beat with pslverr_i=1 (sampled only when ACCESS and pready_i=1); group still runs all N_OPS beats; flag cleared at next group start.
- On last beat completion: data_o <= final sum, err_o <= flag, valid_o=1 next cycle for exactly one cycle. data_o/err_o hold until next result.
- compute_req_i ignored except in IDLE and at last-beat completion.

## Timing
- Reset (preset_i=1 at an edge): state IDLE, all outputs 0 next cycle, accumulator/counters/flag cleared; applies mid-transfer (bus dropped, no valid_o, partial sum discarded).
- Zero-wait group: req sampled edge 0, SETUP cycle 1, ACCESS cycle 2, ... last ACCESS cycle 2*N_OPS, valid_o cycle 2*N_OPS+1.
- Each pready_i=0 cycle adds one cycle of latency.
- Back-to-back: SETUP of next group directly follows last ACCESS; valid_o of previous group coincides with that SETUP cycle.
- prdata_i/pslverr_i sampled only in ACCESS with pready_i=1.

## Configuration
- APB_REDUCE_SAT_EN defined: accumulator unsigned-saturates at 2^DATA_W-1; once saturated stays saturated for rest of group.
- Undefined: sum wraps modulo 2^DATA_W.

## Test plan
- N_OPS=2, start_addr_i=0x10, slave returns 5 then 7, no waits, req pulsed 1 cycle -> paddr 0x10,0x11, data_o=12, valid_o at cycle 5, err_o=0, back to IDLE.
- N_OPS=4, req held high, pready_i low 2 cycles on beat 2 -> paddr stable during waits, 4 beats then next group starts at base+4 with no IDLE cycle.
- start_addr_i=0xFE, N_OPS=4 -> addresses 0xFE,0xFF,0x00,0x01.
- pslverr_i=1 on beat 1 of 2 -> both beats issued, valid_o with err_o=1; next clean group err_o=0.
- Words 0xFFFFFFFF and 0x00000002 -> data_o=0x00000001 without macro, 0xFFFFFFFF with APB_REDUCE_SAT_EN.
- preset_i asserted during ACCESS of beat 1 -> psel_o/penable_o/paddr_o=0 next cycle, no valid_o, new req restarts from start_addr_i.
